// File: rtl/fb_pkg.sv
// Shared types for the framebuffer read engine: address sizing, scan FSM states
// and the pixel record carried through the output FIFO.
package fb_pkg;

  localparam int unsigned PIX_CORDW = 16;
  localparam int unsigned PIX_CIDXW = 4;

  function automatic int unsigned fb_addrw(input int unsigned width, input int unsigned height);
    return $clog2(width * height);
  endfunction

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } state_e;

  typedef struct packed {
    logic signed [PIX_CORDW-1:0] x;
    logic signed [PIX_CORDW-1:0] y;
    logic [PIX_CIDXW-1:0]        cidx;
  } pixel_t;

endpackage

// File: rtl/fb_reader_fifo.sv
// Two-entry synchronous FIFO for pixel records; head is presented directly
// from storage so the output is registered.
module fb_reader_fifo
  import fb_pkg::*;
#(
  parameter type T = pixel_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  T           push_data_i,
  input  logic       pop_i,
  output T           head_o,
  output logic [1:0] count_o,
  output logic       empty_o
);

  T           mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= !wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= !rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/fb_reader.sv
// Framebuffer read engine: scans an inclusive rectangle row-major, reads memory
// and streams (x, y, cidx) with valid/ready. Define FB_READER_CLIP_EN to skip
// cursor positions outside the framebuffer.
module fb_reader
  import fb_pkg::*;
#(
  parameter int CORDW  = 16,
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int CIDXW  = 4,
  parameter int ADDRW  = fb_addrw(WIDTH, HEIGHT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [CORDW-1:0] x0,
  input  logic signed [CORDW-1:0] y0,
  input  logic signed [CORDW-1:0] x1,
  input  logic signed [CORDW-1:0] y1,
  output logic                    mem_re,
  output logic [ADDRW-1:0]        mem_addr,
  input  logic [CIDXW-1:0]        mem_data,
  output logic signed [CORDW-1:0] out_x,
  output logic signed [CORDW-1:0] out_y,
  output logic [CIDXW-1:0]        out_cidx,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  typedef struct packed {
    logic signed [CORDW-1:0] x;
    logic signed [CORDW-1:0] y;
    logic [CIDXW-1:0]        cidx;
  } pix_t;

  localparam logic [ADDRW-1:0]        ROW_STEP = ADDRW'(WIDTH);
  localparam logic signed [CORDW+31:0] WIDTH_X = (CORDW+32)'(WIDTH);

  state_e                  state_q, state_d;
  logic signed [CORDW-1:0] xa_q, xa_d;
  logic signed [CORDW-1:0] xb_q, xb_d;
  logic signed [CORDW-1:0] yb_q, yb_d;
  logic signed [CORDW-1:0] cx_q, cx_d;
  logic signed [CORDW-1:0] cy_q, cy_d;
  logic [ADDRW-1:0]        row_base_q, row_base_d;
  logic                    inflight_q;
  logic signed [CORDW-1:0] rd_x_q;
  logic signed [CORDW-1:0] rd_y_q;

  logic signed [CORDW-1:0] lo_x, hi_x, lo_y, hi_y;
  logic signed [CORDW+31:0] row_prod;
  logic                    pop;
  logic                    credit_ok;
  logic                    in_bounds;
  logic                    issue;
  logic                    advance;
  logic                    last_pos;
  logic [1:0]              fifo_count;
  logic                    fifo_empty;
  pix_t                    fifo_head;
  pix_t                    push_pix;

  always_comb begin
    lo_x     = (x0 < x1) ? x0 : x1;
    hi_x     = (x0 < x1) ? x1 : x0;
    lo_y     = (y0 < y1) ? y0 : y1;
    hi_y     = (y0 < y1) ? y1 : y0;
    row_prod = (CORDW+32)'(lo_y) * WIDTH_X;
  end

`ifdef FB_READER_CLIP_EN
  localparam logic signed [CORDW-1:0] W_LIM = CORDW'(WIDTH);
  localparam logic signed [CORDW-1:0] H_LIM = CORDW'(HEIGHT);
  assign in_bounds = !cx_q[CORDW-1] && (cx_q < W_LIM) && !cy_q[CORDW-1] && (cy_q < H_LIM);
`else
  assign in_bounds = 1'b1;
`endif

  // Credit: buffered + in-flight after this cycle's pop must leave room for one more.
  assign pop       = out_valid & out_ready;
  assign credit_ok = (({1'b0, fifo_count} + {2'b00, inflight_q}) - {2'b00, pop}) < 3'd2;
  assign last_pos  = (cx_q == xb_q) && (cy_q == yb_q);
  assign issue     = (state_q == READ) && in_bounds && credit_ok;
  assign advance   = (state_q == READ) && (credit_ok || !in_bounds);

  always_comb begin
    state_d    = state_q;
    xa_d       = xa_q;
    xb_d       = xb_q;
    yb_d       = yb_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    row_base_d = row_base_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          xa_d       = lo_x;
          xb_d       = hi_x;
          yb_d       = hi_y;
          cx_d       = lo_x;
          cy_d       = lo_y;
          row_base_d = row_prod[ADDRW-1:0];
          state_d    = READ;
        end
      end
      READ: begin
        if (advance) begin
          if (last_pos) begin
            state_d = DRAIN;
          end else if (cx_q == xb_q) begin
            cx_d       = xa_q;
            cy_d       = cy_q + CORDW'(1);
            row_base_d = row_base_q + ROW_STEP;
          end else begin
            cx_d = cx_q + CORDW'(1);
          end
        end
      end
      DRAIN: begin
        // Leave as the last pixel is accepted so done follows it by one cycle.
        if (!inflight_q && (fifo_empty || ((fifo_count == 2'd1) && pop))) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      xa_q       <= '0;
      xb_q       <= '0;
      yb_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      row_base_q <= '0;
      inflight_q <= 1'b0;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
    end else begin
      state_q    <= state_d;
      xa_q       <= xa_d;
      xb_q       <= xb_d;
      yb_q       <= yb_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      row_base_q <= row_base_d;
      inflight_q <= issue;
      if (issue) begin
        rd_x_q <= cx_q;
        rd_y_q <= cy_q;
      end
    end
  end

  always_comb begin
    push_pix      = '0;
    push_pix.x    = rd_x_q;
    push_pix.y    = rd_y_q;
    push_pix.cidx = mem_data;
  end

  fb_reader_fifo #(
    .T(pix_t)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (inflight_q),
    .push_data_i(push_pix),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty)
  );

  assign mem_re    = issue;
  assign mem_addr  = row_base_q + ADDRW'(cx_q);
  assign out_x     = fifo_head.x;
  assign out_y     = fifo_head.y;
  assign out_cidx  = fifo_head.cidx;
  assign out_valid = !fifo_empty;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_fb_reader.sv
// Scoreboard bench for fb_reader: a rectangle-scan reference model fills
// expected address and pixel queues; a negedge monitor pops and compares.
module tb_fb_reader;

  localparam int CORDW  = 16;
  localparam int WIDTH  = 320;
  localparam int HEIGHT = 240;
  localparam int CIDXW  = 4;
  localparam int AW     = $clog2(WIDTH * HEIGHT);
  localparam int AMASK  = (1 << AW) - 1;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  logic signed [CORDW-1:0] x0 = '0;
  logic signed [CORDW-1:0] y0 = '0;
  logic signed [CORDW-1:0] x1 = '0;
  logic signed [CORDW-1:0] y1 = '0;
  logic                    mem_re;
  logic [AW-1:0]           mem_addr;
  logic [CIDXW-1:0]        mem_data = '0;
  logic signed [CORDW-1:0] out_x;
  logic signed [CORDW-1:0] out_y;
  logic [CIDXW-1:0]        out_cidx;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic                    busy;
  logic                    done;

  fb_reader #(
    .CORDW (CORDW),
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .CIDXW (CIDXW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .x0       (x0),
    .y0       (y0),
    .x1       (x1),
    .y1       (y1),
    .mem_re   (mem_re),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .out_x    (out_x),
    .out_y    (out_y),
    .out_cidx (out_cidx),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int c; } pix_s;

  int   tests = 0;
  int   fails = 0;
  pix_s exp_q[$];
  int   addr_q[$];
  bit   sb_en = 1'b0;
  bit   b2b_en = 1'b0;
  bit   strict = 1'b0;
  int   rmode = 0;
  int   mem_xor = 0;
  int   nexp = 0;
  int   pop_base = 0;
  int   done_total = 0;
  int   pop_total = 0;
  int   last_pop_cyc = -10;
  int   cyc = 0;
  int   issued = 0;
  int   popped = 0;
  bit   stalled = 1'b0;
  int   hx, hy, hc;
  pix_s e_m;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Synchronous memory, one-cycle latency; contents derived from the address.
  always @(posedge clk)
    if (mem_re) mem_data <= CIDXW'((int'(mem_addr) & 15) ^ mem_xor);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      issued <= 0;
      popped <= 0;
    end else begin
      cyc <= cyc + 1;
      if (mem_re) issued <= issued + 1;
      if (out_valid && out_ready) popped <= popped + 1;
    end
  end

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (ph == 1 || ph == 2) ? 1'b0 : 1'b1;
          ph = (ph + 1) % 4;
        end
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst || !sb_en) begin
      stalled = 1'b0;
    end else begin
      if (mem_re) begin
        chk("read_expected", (addr_q.size() > 0) ? 1 : 0, 1);
        if (addr_q.size() > 0) chk("mem_addr", int'(mem_addr), addr_q.pop_front());
        chk("credit_le2", ((issued - popped + 1 - ((out_valid && out_ready) ? 1 : 0)) <= 2) ? 1 : 0, 1);
      end
      if (stalled) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_x", int'(out_x), hx);
        chk("hold_y", int'(out_y), hy);
        chk("hold_cidx", int'(out_cidx), hc);
      end
      if (b2b_en && pop_total > pop_base && exp_q.size() > 0)
        chk("b2b_valid", int'(out_valid), 1);
      if (out_valid && out_ready) begin
        chk("pixel_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          e_m = exp_q.pop_front();
          chk("out_x", int'(out_x), e_m.x);
          chk("out_y", int'(out_y), e_m.y);
          chk("out_cidx", int'(out_cidx), e_m.c);
        end
        pop_total++;
        last_pop_cyc = cyc;
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled = 1'b1;
        hx = int'(out_x);
        hy = int'(out_y);
        hc = int'(out_cidx);
      end else begin
        stalled = 1'b0;
      end
      if (done) begin
        done_total++;
        chk("done_drained", exp_q.size(), 0);
        if (strict && nexp > 0) chk("done_latency", cyc - last_pop_cyc, 1);
      end
    end
  end

  // Reference: every (x,y) of the inclusive rectangle, row-major.
  task automatic build(input int ax, input int ay, input int bx, input int by);
    int xa, xb, ya, yb, a;
    xa = (ax < bx) ? ax : bx;
    xb = (ax < bx) ? bx : ax;
    ya = (ay < by) ? ay : by;
    yb = (ay < by) ? by : ay;
    strict = 1'b1;
    for (int y = ya; y <= yb; y++) begin
      for (int x = xa; x <= xb; x++) begin
`ifdef FB_READER_CLIP_EN
        if (x < 0 || x >= WIDTH || y < 0 || y >= HEIGHT) begin
          strict = 1'b0;
          continue;
        end
`endif
        a = (y * WIDTH + x) & AMASK;
        addr_q.push_back(a);
        exp_q.push_back('{x, y, (a & 15) ^ mem_xor});
      end
    end
    nexp = exp_q.size();
  endtask

  task automatic pulse_start(input int ax, input int ay, input int bx, input int by);
    @(posedge clk);
    #1;
    x0 = CORDW'(ax);
    y0 = CORDW'(ay);
    x1 = CORDW'(bx);
    y1 = CORDW'(by);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_rect(input string tag, input int ax, input int ay, input int bx, input int by,
                          input int mode, input bit spurious);
    int dbase, budget, lim, dx, dy;
    build(ax, ay, bx, by);
    rmode    = mode;
    b2b_en   = (mode == 0) && strict;
    pop_base = pop_total;
    dbase    = done_total;
    dx = (ax > bx) ? ax - bx : bx - ax;
    dy = (ay > by) ? ay - by : by - ay;
    lim = 100 + 20 * (dx + 1) * (dy + 1);
    pulse_start(ax, ay, bx, by);
    if (spurious && nexp >= 4) pulse_start(0, 0, 7, 7);
    budget = 0;
    while (done_total == dbase && budget < lim) begin
      @(posedge clk);
      budget++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_once"}, done_total - dbase, 1);
    chk({tag, "_pix_count"}, pop_total - pop_base, nexp);
    chk({tag, "_pix_left"}, exp_q.size(), 0);
    chk({tag, "_addr_left"}, addr_q.size(), 0);
    chk({tag, "_busy_idle"}, int'(busy), 0);
    exp_q.delete();
    addr_q.delete();
    b2b_en = 1'b0;
  endtask

  task automatic reset_mid();
    int budget;
    build(2, 3, 4, 4);
    rmode    = 0;
    b2b_en   = 1'b1;
    pop_base = pop_total;
    pulse_start(2, 3, 4, 4);
    budget = 0;
    while (pop_total - pop_base < 3 && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    chk("rstmid_three_popped", (pop_total - pop_base >= 3) ? 1 : 0, 1);
    @(posedge clk);
    #2;
    sb_en  = 1'b0;
    b2b_en = 1'b0;
    rst    = 1'b1;
    #1;
    chk("rstmid_out_valid", int'(out_valid), 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_mem_re", int'(mem_re), 0);
    chk("rstmid_done", int'(done), 0);
    chk("rstmid_out_x", int'(out_x), 0);
    chk("rstmid_out_cidx", int'(out_cidx), 0);
    exp_q.delete();
    addr_q.delete();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst   = 1'b0;
    sb_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int ax, ay, w, h;
    #12;
    chk("reset_mem_re", int'(mem_re), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_mem_addr", int'(mem_addr), 0);
    chk("reset_out_x", int'(out_x), 0);
    chk("reset_out_y", int'(out_y), 0);
    chk("reset_out_cidx", int'(out_cidx), 0);
    @(posedge clk);
    #2;
    rst   = 1'b0;
    sb_en = 1'b1;

    mem_xor = 0;
    run_rect("rect", 2, 3, 4, 4, 0, 1'b0);
    run_rect("swap", 4, 4, 2, 3, 0, 1'b0);
    run_rect("stall", 2, 3, 4, 4, 1, 1'b0);
    run_rect("single", 319, 239, 319, 239, 0, 1'b0);
    run_rect("left_edge", -2, 0, 1, 0, 0, 1'b0);
    run_rect("far_right", 400, 10, 410, 10, 0, 1'b0);
    reset_mid();
    run_rect("after_rst", 2, 3, 4, 4, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      mem_xor = $urandom_range(0, 15);
      ax = int'($urandom_range(0, 335)) - 8;
      ay = int'($urandom_range(0, 247)) - 4;
      w  = $urandom_range(0, 5);
      h  = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1)
        run_rect("rand", ax + w, ay + h, ax, ay, $urandom_range(0, 2), 1'b1);
      else
        run_rect("rand", ax, ay, ax + w, ay + h, $urandom_range(0, 2), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
